// File: rtl/slip_pad_bus_seq.sv
// Bus-cycle sequencer driving registered bidirectional pad cells on the Slipstream data bus.
// Optional macro SLIP_PAD_BUS_TURNAROUND_EN adds a one-cycle released TURN state after writes.
module slip_pad_bus_seq #(
  parameter int WIDTH = 8,
  parameter int WAITS = 2
) (
  input  logic             MasterClock,
  input  logic             Reset,
  input  logic             Req,
  input  logic             Wr,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Ack,
  output logic [WIDTH-1:0] RdData,
  output logic [WIDTH-1:0] PadI,
  output logic             PadEN,
  output logic             PadTN,
  output logic             PadPI,
  input  logic [WIDTH-1:0] PadZI,
  output logic             nStrobe
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    CAPTURE,
    TURN
  } state_t;

  localparam logic [3:0] STROBE_LOAD = 4'(WAITS - 1);
  localparam logic [3:0] SETUP_LOAD  = 4'd1;

  state_t           state, state_d;
  logic [3:0]       cnt, cnt_d;
  logic             is_wr, wr_d;
  logic [WIDTH-1:0] pad_i_d, rd_d;
  logic             ack_d, busy_d, en_d, strobe_n_d;

  assign PadTN = 1'b1;
  assign PadPI = 1'b1;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wr_d    = is_wr;
    pad_i_d = PadI;
    rd_d    = RdData;
    ack_d   = 1'b0;
    case (state)
      IDLE: begin
        if (Req) begin
          state_d = SETUP;
          wr_d    = Wr;
          cnt_d   = SETUP_LOAD;
          if (Wr) pad_i_d = WrData;
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) state_d = HOLD;
        else             cnt_d   = cnt - 4'd1;
      end
      HOLD: begin
        if (!is_wr) begin
          state_d = CAPTURE;
        end else begin
`ifdef SLIP_PAD_BUS_TURNAROUND_EN
          state_d = TURN;
`else
          state_d = IDLE;
          ack_d   = 1'b1;
`endif
        end
      end
      CAPTURE: begin
        // ZI is inverted and one cycle behind the pin; registering here makes RdData change together with Ack
        state_d = IDLE;
        ack_d   = 1'b1;
        rd_d    = ~PadZI;
      end
      TURN: begin
        state_d = IDLE;
        ack_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    strobe_n_d = (state_d != STROBE);
    en_d       = !(wr_d && (state_d inside {SETUP, STROBE, HOLD}));
  end

  // Outputs are registered from the next-state decode so they line up with the state register
  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      is_wr   <= 1'b0;
      Busy    <= 1'b0;
      Ack     <= 1'b0;
      RdData  <= '0;
      PadI    <= '0;
      PadEN   <= 1'b1;
      nStrobe <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      is_wr   <= wr_d;
      Busy    <= busy_d;
      Ack     <= ack_d;
      RdData  <= rd_d;
      PadI    <= pad_i_d;
      PadEN   <= en_d;
      nStrobe <= strobe_n_d;
    end
  end

endmodule

// File: tb/tb_slip_pad_bus_seq.sv
// Self-checking bench for slip_pad_bus_seq: expected waveforms come from per-transaction cycle offsets.
// Honours SLIP_PAD_BUS_TURNAROUND_EN for the extra write cycle.
module tb_slip_pad_bus_seq;
  localparam int WIDTH = 8;
  localparam int W     = 3;
`ifdef SLIP_PAD_BUS_TURNAROUND_EN
  localparam int TURN_CYC = 1;
`else
  localparam int TURN_CYC = 0;
`endif

  logic             clk = 1'b0;
  logic             reset, req, wr;
  logic [WIDTH-1:0] wr_data;
  logic             busy, ack, pad_en, pad_tn, pad_pi, strobe_n;
  logic [WIDTH-1:0] rd_data, pad_i;
  logic [WIDTH-1:0] pad_zi = '0;
  logic [WIDTH-1:0] pin = '0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_rd   = '0;
  logic [WIDTH-1:0] exp_padi = '0;

  slip_pad_bus_seq #(.WIDTH(WIDTH), .WAITS(W)) dut (
    .MasterClock(clk),
    .Reset(reset),
    .Req(req),
    .Wr(wr),
    .WrData(wr_data),
    .Busy(busy),
    .Ack(ack),
    .RdData(rd_data),
    .PadI(pad_i),
    .PadEN(pad_en),
    .PadTN(pad_tn),
    .PadPI(pad_pi),
    .PadZI(pad_zi),
    .nStrobe(strobe_n)
  );

  always #5 clk = ~clk;

  // Pad cell input register: ZI is the inverted pin, one cycle late
  always @(posedge clk) pad_zi <= ~pin;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, " busy"}, 32'(busy), 32'd0);
    check_output({tag, " ack"}, 32'(ack), 32'd0);
    check_output({tag, " nstrobe"}, 32'(strobe_n), 32'd1);
    check_output({tag, " pad_en"}, 32'(pad_en), 32'd1);
    check_output({tag, " pad_tn"}, 32'(pad_tn), 32'd1);
    check_output({tag, " pad_pi"}, 32'(pad_pi), 32'd1);
    check_output({tag, " rd_data"}, 32'(rd_data), 32'(exp_rd));
    check_output({tag, " pad_i"}, 32'(pad_i), 32'(exp_padi));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_idle("idle");
      pin = WIDTH'($urandom);
    end
  endtask

  // Called at a negedge; runs one request from acceptance to Ack (or to an abort by reset at offset abort_at)
  task automatic apply_stimulus(input logic is_wr, input logic [WIDTH-1:0] data,
                                input logic [WIDTH-1:0] pin_val, input bit jitter, input int abort_at);
    int len;
    len     = is_wr ? (4 + W + TURN_CYC) : (5 + W);
    req     = 1'b1;
    wr      = is_wr;
    wr_data = data;
    pin     = pin_val;
    @(posedge clk);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (is_wr && k == 1) exp_padi = data;
      if (!is_wr && k == len) exp_rd = pin_val;
      check_output("busy", 32'(busy), 32'(k < len));
      check_output("ack", 32'(ack), 32'(k == len));
      check_output("nstrobe", 32'(strobe_n), 32'(!(k >= 3 && k <= 2 + W)));
      check_output("pad_en", 32'(pad_en), 32'(!(is_wr && k <= 3 + W)));
      check_output("pad_i", 32'(pad_i), 32'(exp_padi));
      check_output("rd_data", 32'(rd_data), 32'(exp_rd));
      check_output("pad_tn", 32'(pad_tn), 32'd1);
      check_output("pad_pi", 32'(pad_pi), 32'd1);
      if (k == abort_at) begin
        reset = 1'b1;
        req   = 1'b0;
        @(negedge clk);
        exp_rd   = '0;
        exp_padi = '0;
        check_idle("abort");
        reset = 1'b0;
        return;
      end
      if (jitter && k < len) begin
        req     = 1'($urandom_range(0, 1));
        wr      = 1'($urandom_range(0, 1));
        wr_data = WIDTH'($urandom);
      end
      if (k == len) req = 1'b0;
    end
  endtask

  initial begin
    logic             rw;
    logic [WIDTH-1:0] d, p;
    bit               j;
    reset   = 1'b1;
    req     = 1'b0;
    wr      = 1'b0;
    wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    idle_cycles(2);

    $display("[TB] directed write A5");
    apply_stimulus(1'b1, 8'hA5, 8'h00, 1'b0, 0);
    idle_cycles(2);

    $display("[TB] directed read 3C");
    apply_stimulus(1'b0, 8'h00, 8'h3C, 1'b0, 0);
    idle_cycles(1);

    $display("[TB] back-to-back write then read");
    apply_stimulus(1'b1, 8'h5A, 8'h11, 1'b0, 0);
    apply_stimulus(1'b0, 8'h00, 8'h96, 1'b0, 0);
    idle_cycles(1);

    $display("[TB] request jitter while busy");
    apply_stimulus(1'b0, 8'h00, 8'h71, 1'b1, 0);
    idle_cycles(1);
    apply_stimulus(1'b1, 8'hC9, 8'h00, 1'b1, 0);
    idle_cycles(1);

    $display("[TB] reset during strobe");
    apply_stimulus(1'b1, 8'hE1, 8'h00, 1'b0, 4);
    idle_cycles(2);
    apply_stimulus(1'b0, 8'h00, 8'h4B, 1'b0, 0);
    idle_cycles(1);

    $display("[TB] random transactions");
    for (int t = 0; t < 16; t++) begin
      rw = 1'($urandom_range(0, 1));
      d  = WIDTH'($urandom);
      p  = WIDTH'($urandom);
      j  = 1'($urandom_range(0, 1));
      apply_stimulus(rw, d, p, j, 0);
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
